// File: rtl/sramlike_pkg.sv
// Shared types for the SRAM-like I/D arbiter:
// FSM states, owner encoding and transfer sizes.
package sramlike_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sramlike_arbiter_rr_arb2.sv
// Two-input round-robin grant; on contention the side
// that did not win the previous contended grant wins.
module rr_arb2
  import sramlike_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_inst,
  input  logic req_data,
  input  logic take,
  output logic gnt_inst,
  output logic gnt_data
);

  logic last_win_q;
  logic last_win_d;
  logic both;

  assign both = req_inst & req_data;

  // Grant by priority; remember the winner only on contention.
  always_comb begin
    gnt_inst   = req_inst & (~req_data | (last_win_q == OWN_DATA));
    gnt_data   = req_data & (~req_inst | (last_win_q == OWN_INST));
    last_win_d = last_win_q;
    if (take && both) begin
      last_win_d = gnt_data ? OWN_DATA : OWN_INST;
    end
  end

  // Last contended winner register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win_q <= OWN_INST;
    end else begin
      last_win_q <= last_win_d;
    end
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Shares one SRAM-like master port between I-cache and D-cache
// with one outstanding transaction and flush-dropped fetches.
module sramlike_arbiter
  import sramlike_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          flush,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          drop_q, drop_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          idle;
  logic          gnt_inst, gnt_data;
  logic          done;
  logic          flush_inst;

  // Reset gates the combinational grant so outputs drop at once.
  assign idle = aresetn & (state_q == IDLE);

  rr_arb2 u_arb (
    .clk      (aclk),
    .rst_n    (aresetn),
    .req_inst (inst_req),
    .req_data (data_req),
    .take     (idle),
    .gnt_inst (gnt_inst),
    .gnt_data (gnt_data)
  );

  assign flush_inst = flush & (owner_q == OWN_INST);

  // Next-state, grant and request capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    drop_d       = drop_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (idle && gnt_inst) begin
          inst_addr_ok = 1'b1;
          owner_d      = OWN_INST;
          wr_d         = inst_wr;
          size_d       = inst_size;
          addr_d       = inst_addr;
          wdata_d      = inst_wdata;
          state_d      = ADDR;
        end else if (idle && gnt_data) begin
          data_addr_ok = 1'b1;
          owner_d      = OWN_DATA;
          wr_d         = data_wr;
          size_d       = data_size;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (flush_inst) drop_d = 1'b1;
        if (mem_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (flush_inst) drop_d = 1'b1;
        if (mem_data_ok) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and request registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      owner_q <= OWN_DATA;
      drop_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req   = (state_q == ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // A flush in the completing cycle also swallows the fetch.
  assign done         = (state_q == DATA) & mem_data_ok;
  assign inst_data_ok = done & (owner_q == OWN_INST)
                      & ~drop_q & ~flush;
  assign data_data_ok = done & (owner_q == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  ap_no_resp_idle: assert property (
    @(posedge aclk) disable iff (!aresetn)
    (state_q == IDLE) |-> !(mem_addr_ok || mem_data_ok)
  ) else $error("response while idle");

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: directed scenarios with literal
// expectations plus random traffic against a transaction model.
module tb_sramlike_arbiter;
  import sramlike_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          flush = 1'b0;
  logic          inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]    inst_size = '0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_wdata = '0;
  logic [DW-1:0] inst_rdata;
  logic          inst_addr_ok, inst_data_ok;
  logic          data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]    data_size = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] data_rdata;
  logic          data_addr_ok, data_data_ok;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_addr_ok = 1'b0, mem_data_ok = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  sramlike_arbiter #(.AW(AW), .DW(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  // Transaction model: phase 0 free, 1 address offered, 2 awaiting data.
  int         ph = 0;
  int         cnt = 0;
  bit         own = OWN_DATA;
  bit         drp = 1'b0;
  bit         last = OWN_INST;
  bit         t_wr;
  bit [1:0]   t_size;
  bit [31:0]  t_addr, t_wdata;
  bit         rnd = 1'b0;
  bit         ipend = 1'b0, dpend = 1'b0;

  logic        o_iaok, o_daok, o_idok, o_ddok, o_mreq, o_mwr;
  logic [31:0] o_maddr, o_mwdata, o_irdata, o_drdata;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; drp = 1'b0; last = OWN_INST; own = OWN_DATA;
    ipend = 1'b0; dpend = 1'b0; cnt = 0;
  endtask

  // One clock: called at posedge+1, compares at negedge.
  task automatic step();
    bit ei, ed, edi, edd;
    if (rnd) begin
      mem_addr_ok = (ph == 1) && (cnt == 0);
      mem_data_ok = (ph == 2) && (cnt == 0);
      mem_rdata   = $urandom;
      flush       = ($urandom % 6) == 0;
    end
    ei  = (ph == 0) && inst_req && (!data_req || last == OWN_DATA);
    ed  = (ph == 0) && data_req && !ei;
    edi = (ph == 2) && mem_data_ok && own == OWN_INST
          && !drp && !flush;
    edd = (ph == 2) && mem_data_ok && own == OWN_DATA;
    @(negedge aclk);
    o_iaok = inst_addr_ok; o_daok = data_addr_ok;
    o_idok = inst_data_ok; o_ddok = data_data_ok;
    o_mreq = mem_req; o_mwr = mem_wr;
    o_maddr = mem_addr; o_mwdata = mem_wdata;
    o_irdata = inst_rdata; o_drdata = data_rdata;
    chk("inst_addr_ok", 32'(o_iaok), 32'(ei));
    chk("data_addr_ok", 32'(o_daok), 32'(ed));
    chk("mem_req", 32'(o_mreq), 32'(ph == 1));
    chk("inst_data_ok", 32'(o_idok), 32'(edi));
    chk("data_data_ok", 32'(o_ddok), 32'(edd));
    if (ph == 1) begin
      chk("mem_addr", o_maddr, t_addr);
      chk("mem_wr", 32'(o_mwr), 32'(t_wr));
      chk("mem_size", 32'(mem_size), 32'(t_size));
      chk("mem_wdata", o_mwdata, t_wdata);
    end
    if (edi) chk("inst_rdata", o_irdata, mem_rdata);
    if (edd) chk("data_rdata", o_drdata, mem_rdata);
    case (ph)
      0: if (ei || ed) begin
        if (inst_req && data_req) last = ed ? OWN_DATA : OWN_INST;
        own = ed ? OWN_DATA : OWN_INST;
        if (ed) begin
          t_wr = data_wr; t_size = data_size;
          t_addr = data_addr; t_wdata = data_wdata; dpend = 1'b0;
        end else begin
          t_wr = inst_wr; t_size = inst_size;
          t_addr = inst_addr; t_wdata = inst_wdata; ipend = 1'b0;
        end
        ph = 1; cnt = $urandom % 3;
      end
      1: begin
        if (flush && own == OWN_INST) drp = 1'b1;
        if (mem_addr_ok) begin
          ph = 2; cnt = $urandom % 3;
        end else if (cnt > 0) cnt--;
      end
      default: begin
        if (flush && own == OWN_INST) drp = 1'b1;
        if (mem_data_ok) begin
          ph = 0; drp = 1'b0;
        end else if (cnt > 0) cnt--;
      end
    endcase
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  // Zero-wait slave until the model is free again.
  task automatic drain();
    for (int i = 0; i < 10 && ph != 0; i++) begin
      mem_addr_ok = (ph == 1);
      mem_data_ok = (ph == 2);
      step();
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    chk("drain_free", 32'(ph), 32'd0);
  endtask

  initial begin
    bit [5:0] seq;
    int ng;
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Lone inst read.
    inst_req = 1; inst_wr = 0; inst_size = SZ_WORD;
    inst_addr = 32'hBFC00000;
    step();
    chk("t1_iaok", 32'(o_iaok), 32'd1);
    inst_req = 0;
    step();
    chk("t1_mreq", 32'(o_mreq), 32'd1);
    chk("t1_maddr", o_maddr, 32'hBFC00000);
    step();
    mem_addr_ok = 1; step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C08BFAF;
    step();
    mem_data_ok = 0;
    chk("t1_idok", 32'(o_idok), 32'd1);
    chk("t1_irdata", o_irdata, 32'h3C08BFAF);
    chk("t1_ddok", 32'(o_ddok), 32'd0);

    // Simultaneous after reset: data first.
    do_reset();
    inst_req = 1; inst_wr = 0; inst_addr = 32'h1000;
    data_req = 1; data_wr = 1; data_size = SZ_WORD;
    data_addr = 32'h2000; data_wdata = 32'hDEADBEEF;
    step();
    chk("t2_daok", 32'(o_daok), 32'd1);
    chk("t2_iaok", 32'(o_iaok), 32'd0);
    data_req = 0; mem_addr_ok = 1;
    step();
    chk("t2_mwr", 32'(o_mwr), 32'd1);
    chk("t2_mwdata", o_mwdata, 32'hDEADBEEF);
    mem_addr_ok = 0; mem_data_ok = 1;
    step();
    chk("t2_ddok", 32'(o_ddok), 32'd1);
    mem_data_ok = 0;
    step();
    chk("t2_iaok_late", 32'(o_iaok), 32'd1);
    inst_req = 0;
    drain();

    // Continuous contention alternates D,I,D,I,D,I.
    do_reset();
    inst_req = 1; data_req = 1; data_wr = 0;
    seq = '0; ng = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      mem_addr_ok = (ph == 1); mem_data_ok = (ph == 2);
      step();
      if (o_iaok || o_daok) begin
        seq = {seq[4:0], o_daok}; ng++;
      end
    end
    chk("t3_ngrants", 32'(ng), 32'd6);
    chk("t3_order", 32'(seq), 32'b101010);
    inst_req = 0; data_req = 0;
    drain();

    // Flush during inst DATA swallows the response.
    inst_req = 1; inst_addr = 32'h500;
    step();
    inst_req = 0; mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; flush = 1;
    step();
    flush = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    step();
    mem_data_ok = 0;
    chk("t4_idok_dropped", 32'(o_idok), 32'd0);
    inst_req = 1; inst_addr = 32'h504;
    step();
    inst_req = 0;
    drain();
    chk("t4_idok_next", 32'(o_idok), 32'd1);

    // Flush never drops a data read.
    data_req = 1; data_wr = 0; data_addr = 32'h600;
    step();
    data_req = 0; mem_addr_ok = 1; flush = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_data_ok = 0; flush = 0;
    chk("t5_ddok", 32'(o_ddok), 32'd1);
    chk("t5_drdata", o_drdata, 32'hCAFEF00D);

    // Async reset while in ADDR.
    inst_req = 1; inst_addr = 32'h3000;
    step();
    inst_req = 0;
    data_req = 1; data_addr = 32'h4000;
    aresetn = 0;
    #1;
    chk("t6_mreq", 32'(mem_req), 32'd0);
    chk("t6_maddr", mem_addr, 32'd0);
    chk("t6_daok", 32'(data_addr_ok), 32'd0);
    chk("t6_iaok", 32'(inst_addr_ok), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1;
    model_reset();
    step();
    chk("t6_regrant", 32'(o_daok), 32'd1);
    data_req = 0;
    drain();

    // Random traffic.
    do_reset();
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!ipend && ($urandom % 3) == 0) begin
        ipend = 1; inst_wr = $urandom % 2;
        inst_size = 2'($urandom % 3);
        inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!dpend && ($urandom % 3) == 0) begin
        dpend = 1; data_wr = $urandom % 2;
        data_size = 2'($urandom % 3);
        data_addr = $urandom; data_wdata = $urandom;
      end
      inst_req = ipend; data_req = dpend;
      step();
    end
    rnd = 0; inst_req = 0; data_req = 0; flush = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
